// File: rtl/v_pkg.sv
// v_pkg: shared types and constants for the vector load packer
package v_pkg;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;
   localparam logic [2:0] LMUL_1 = 3'b000;
   localparam logic [2:0] LMUL_2 = 3'b001;
   localparam logic [2:0] LMUL_4 = 3'b010;
   localparam int WORD_W = 32;
   localparam int VREG_W = 128;
   function automatic logic [3:0] last_beat(input logic [2:0] lmul);
      return lmul == LMUL_4 ? 4'd15 : lmul == LMUL_2 ? 4'd7 : 4'd3;
   endfunction
   function automatic logic [4:0] align_mask(input logic [2:0] lmul);
      return lmul == LMUL_4 ? 5'd3 : lmul == LMUL_2 ? 5'd1 : 5'd0;
   endfunction
endpackage

// File: rtl/v_load_packer_if.sv
// v_load_packer_if: command, status, memory and regfile bundle of the load packer; stride port exists only with V_LD_STRIDE_EN
interface v_load_packer_if;
   import v_pkg::*;
   logic              start;
   logic [31:0]       base_addr;
   logic [4:0]        dest_reg;
   logic [2:0]        lmul;
`ifdef V_LD_STRIDE_EN
   logic [31:0]       stride;
`endif
   logic              busy;
   logic              done;
   logic              err;
   logic              mem_rd_req;
   logic [31:0]       mem_addr;
   logic              mem_rd_valid;
   logic [WORD_W-1:0] mem_rd_data;
   logic              reg_wr_en;
   logic [4:0]        reg_wr_addr;
   logic [VREG_W-1:0] reg_wr_data;
   logic [VREG_W-1:0] reg_wr_data_2;
   logic [VREG_W-1:0] reg_wr_data_3;
   logic [VREG_W-1:0] reg_wr_data_4;
   modport slave (
      input  start, base_addr, dest_reg, lmul,
`ifdef V_LD_STRIDE_EN
             stride,
`endif
             mem_rd_valid, mem_rd_data,
      output busy, done, err, mem_rd_req, mem_addr, reg_wr_en, reg_wr_addr,
             reg_wr_data, reg_wr_data_2, reg_wr_data_3, reg_wr_data_4
   );
   modport master (
      output start, base_addr, dest_reg, lmul,
`ifdef V_LD_STRIDE_EN
             stride,
`endif
             mem_rd_valid, mem_rd_data,
      input  busy, done, err, mem_rd_req, mem_addr, reg_wr_en, reg_wr_addr,
             reg_wr_data, reg_wr_data_2, reg_wr_data_3, reg_wr_data_4
   );
endinterface

// File: rtl/v_ld_agen.sv
// v_ld_agen: load address generator, steps by 4 per beat or by a latched stride when V_LD_STRIDE_EN is defined
module v_ld_agen (
   input  logic        clk,
   input  logic        nrst,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] base,
`ifdef V_LD_STRIDE_EN
   input  logic [31:0] stride,
`endif
   output logic [31:0] addr
);
   logic [31:0] inc;
`ifdef V_LD_STRIDE_EN
   // stride is captured together with the base address of an accepted command
   always_ff @(posedge clk)
      if (!nrst) inc <= '0;
      else if (load) inc <= stride;
`else
   assign inc = 32'd4;
`endif
   // current word address; plain 32-bit addition gives the modulo-2^32 wrap
   always_ff @(posedge clk)
      if (!nrst) addr <= '0;
      else if (load) addr <= base;
      else if (step) addr <= addr + inc;
endmodule

// File: rtl/v_load_packer.sv
// v_load_packer: fetches 4/8/16 words one read at a time and packs them into 1/2/4 vector registers; V_LD_STRIDE_EN adds a stride input
module v_load_packer
   import v_pkg::*;
(
   input logic           clk,
   input logic           nrst,
   v_load_packer_if.slave bus
);
   state_t                 state;
   logic [3:0]             cnt;
   logic [3:0]             last;
   logic [4:0]             dest;
   logic [3:0][VREG_W-1:0] vbuf;
   logic                   busy;
   logic                   done;
   logic                   err;
   logic                   rd_req;
   logic                   wr_en;
   logic                   accept;
   logic                   step;
   logic [31:0]            addr;
   assign accept = state == IDLE && bus.start && (bus.dest_reg & align_mask(bus.lmul)) == 5'd0;
   assign step   = state == WAIT && bus.mem_rd_valid;
   v_ld_agen u_agen (
      .clk   (clk),
      .nrst  (nrst),
      .load  (accept),
      .step  (step),
      .base  (bus.base_addr),
`ifdef V_LD_STRIDE_EN
      .stride(bus.stride),
`endif
      .addr  (addr)
   );
   assign bus.busy          = busy;
   assign bus.done          = done;
   assign bus.err           = err;
   assign bus.mem_rd_req    = rd_req;
   assign bus.mem_addr      = addr;
   assign bus.reg_wr_en     = wr_en;
   assign bus.reg_wr_addr   = dest;
   assign bus.reg_wr_data   = vbuf[0];
   assign bus.reg_wr_data_2 = vbuf[1];
   assign bus.reg_wr_data_3 = vbuf[2];
   assign bus.reg_wr_data_4 = vbuf[3];
   // command FSM: one outstanding read per beat, pulses registered one state ahead
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state  <= IDLE;
         cnt    <= '0;
         last   <= '0;
         dest   <= '0;
         vbuf   <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         rd_req <= 1'b0;
         wr_en  <= 1'b0;
      end else begin
         done   <= 1'b0;
         err    <= 1'b0;
         rd_req <= 1'b0;
         wr_en  <= 1'b0;
         case (state)
            IDLE:
               if (bus.start) begin
                  if (accept) begin
                     state  <= REQ;
                     busy   <= 1'b1;
                     rd_req <= 1'b1;
                     cnt    <= '0;
                     last   <= last_beat(bus.lmul);
                     dest   <= bus.dest_reg;
                     vbuf   <= '0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            REQ: state <= WAIT;
            WAIT:
               if (bus.mem_rd_valid) begin
                  vbuf[cnt[3:2]][{cnt[1:0], 5'd0} +: WORD_W] <= bus.mem_rd_data;
                  cnt <= cnt + 4'd1;
                  if (cnt == last) begin
                     state <= WRITE;
                     wr_en <= 1'b1;
                     done  <= 1'b1;
                  end else begin
                     state  <= REQ;
                     rd_req <= 1'b1;
                  end
               end
            WRITE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_v_load_packer.sv
// tb_v_load_packer: scoreboard bench for v_load_packer; exercises stride only when V_LD_STRIDE_EN is defined
module tb_v_load_packer;
   import v_pkg::*;
   typedef struct packed {
      logic [4:0]             dest;
      logic [3:0][VREG_W-1:0] d;
   } wr_t;
   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   int          n_vec = 0;
   int          n_bad = 0;
   int          n_req = 0;
   int          rsp_wait = 0;
   int          rsp_delay = 1;
   int          cyc;
   logic [31:0] rsp_data = '0;
   logic [31:0] exp_addr[$];
   logic [31:0] words[$];
   wr_t         exp_wr[$];
   v_load_packer_if bus();
   v_load_packer dut (.clk(clk), .nrst(nrst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(negedge clk);
      #1;
   endtask
   // memory responder and output monitor, working on the falling edge
   initial begin : mon
      wr_t e;
      bus.mem_rd_valid = 1'b0;
      bus.mem_rd_data  = '0;
      forever begin
         @(negedge clk);
         bus.mem_rd_valid = 1'b0;
         if (rsp_wait > 0) begin
            rsp_wait--;
            if (rsp_wait == 0) begin
               bus.mem_rd_valid = 1'b1;
               bus.mem_rd_data  = rsp_data;
            end
         end
         if (bus.mem_rd_req) begin
            n_req++;
            if (exp_addr.size() == 0) chk("unexp_req", 1, 0);
            else chk("mem_addr", bus.mem_addr, exp_addr.pop_front());
            rsp_data = words.size() != 0 ? words.pop_front() : 32'hDEAD_BEEF;
            rsp_wait = rsp_delay;
         end
         if (bus.reg_wr_en) begin
            if (exp_wr.size() == 0) chk("unexp_wr", 1, 0);
            else begin
               e = exp_wr.pop_front();
               chk("wr_addr", bus.reg_wr_addr, e.dest);
               chk("wr_data", bus.reg_wr_data, e.d[0]);
               chk("wr_data_2", bus.reg_wr_data_2, e.d[1]);
               chk("wr_data_3", bus.reg_wr_data_3, e.d[2]);
               chk("wr_data_4", bus.reg_wr_data_4, e.d[3]);
            end
         end
      end
   end
   task automatic cmd(input logic [31:0] base, input logic [4:0] dest, input logic [2:0] lm,
                      input int dly, input logic [31:0] stp, input logic [31:0] w0, input logic [31:0] winc);
      wr_t         e;
      int          n;
      logic [31:0] w;
      n = lm == LMUL_4 ? 16 : lm == LMUL_2 ? 8 : 4;
      e.dest = dest;
      e.d = '0;
      for (int k = 0; k < n; k++) begin
         w = w0 + winc * 32'(k);
         e.d[k / 4][(k % 4) * 32 +: 32] = w;
         words.push_back(w);
         exp_addr.push_back(base + stp * 32'(k));
      end
      exp_wr.push_back(e);
      rsp_delay     = dly;
      bus.base_addr = base;
      bus.dest_reg  = dest;
      bus.lmul      = lm;
`ifdef V_LD_STRIDE_EN
      bus.stride    = stp;
`endif
      bus.start     = 1'b1;
   endtask
   task automatic run(input bit hold, output int c);
      c = 0;
      do begin
         tick;
         c++;
         if (!hold) bus.start = 1'b0;
         else chk("busy_hold", bus.busy, 1);
      end while (!bus.done && c < 300);
      if (!bus.done) chk("done_timeout", bus.done, 1);
      bus.start = 1'b0;
      tick;
      chk("done_pulse", bus.done, 0);
      chk("idle_after", bus.busy, 0);
   endtask
   initial begin
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.dest_reg  = '0;
      bus.lmul      = '0;
`ifdef V_LD_STRIDE_EN
      bus.stride    = 32'd4;
`endif
      repeat (3) tick;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_req", bus.mem_rd_req, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_wr_en", bus.reg_wr_en, 0);
      chk("rst_data", bus.reg_wr_data, 0);
      nrst = 1'b1;
      tick;
      cmd(32'h100, 5'd3, LMUL_1, 1, 32'd4, 32'h11, 32'h11);
      run(1'b0, cyc);
      chk("lat_lmul1", cyc, 9);
      cmd(32'h2000, 5'd8, LMUL_4, 3, 32'd4, 32'hC0DE_0000, 32'h0101_0101);
      run(1'b0, cyc);
      bus.lmul     = LMUL_2;
      bus.dest_reg = 5'd5;
      bus.start    = 1'b1;
      tick;
      bus.start = 1'b0;
      chk("rej_err", bus.err, 1);
      chk("rej_busy", bus.busy, 0);
      repeat (4) begin
         tick;
         chk("rej_err_low", bus.err, 0);
         chk("rej_idle", bus.busy, 0);
      end
      n_req = 0;
      cmd(32'h300, 5'd0, LMUL_1, 3, 32'd4, 32'h55, 32'h1);
      tick;
      bus.start = 1'b0;
      for (int i = 0; i < 50 && n_req < 3; i++) tick;
      chk("abort_reqs", n_req, 3);
      tick;
      chk("abort_in_wait", bus.busy, 1);
      nrst      = 1'b0;
      rsp_delay = 1;
      exp_addr.delete();
      words.delete();
      exp_wr.delete();
      tick;
      chk("abort_busy", bus.busy, 0);
      chk("abort_addr", bus.mem_addr, 0);
      chk("abort_data", bus.reg_wr_data, 0);
      nrst = 1'b1;
      cmd(32'h400, 5'd1, LMUL_1, 1, 32'd4, 32'hA1, 32'h1);
      run(1'b0, cyc);
      chk("lat_after_abort", cyc, 9);
      cmd(32'hFFFF_FFF8, 5'd2, LMUL_1, 2, 32'd4, 32'h9000_0001, 32'h10);
      run(1'b1, cyc);
`ifdef V_LD_STRIDE_EN
      cmd(32'h0, 5'd4, LMUL_1, 1, 32'h20, 32'h7, 32'h7);
      run(1'b0, cyc);
`endif
      repeat (3) tick;
      chk("addr_q_left", exp_addr.size(), 0);
      chk("wr_q_left", exp_wr.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
